proc_instr_feeder: RTL and testbench
====================================

# proc_instr_feeder

Upstream instruction sequencer for the 9-bit bus processor. Holds a program in an internal synchronous RAM and steps through it. For each instruction it presents the word on `DIN` with a one-cycle `Run` pulse. For `mvi` it then holds the immediate word on `DIN`. It waits for the processor's `Done` before advancing, and stops with a halt or error status.

## Interface
Parameters:
- `AW`, 8: RAM address / PC width (depth 2^AW words).
- `TIMEOUT`, 16: maximum WAIT cycles allowed before `Done`; range 1..255.

Ports:
- `Clock`  in  1: single clock; all logic on the rising edge.
- `Reset`  in  1: synchronous, active-high.
- `Start`  in  1: begin execution from address 0; sampled in IDLE and HALT only.
- `ProgLen`  in  AW+1: number of program words; sampled on accepted `Start`.
- `WrEn`  in  1: RAM write strobe; honoured only in IDLE and HALT.
- `WrAddr`  in  AW: RAM write address.
- `WrData`  in  9: RAM write data.
- `Done`  in  1: processor completion; sampled only in WAIT.
- `DIN`  out  9: word presented to the processor.
- `Run`  out  1: one-cycle issue pulse.
- `PC`  out  AW+1: address of the current instruction.
- `InstrCount`  out  16: number of instructions completed; saturates at 16'hFFFF.
- `Busy`  out  1: high in every state except IDLE, HALT and ERROR.
- `Halted`  out  1: high in HALT.
- `Error`  out  1: high in ERROR.
- `ErrCode`  out  2: 01 = Done timeout, 10 = truncated `mvi`; 00 otherwise.

## Operation
Instruction format:
- Bits [8:6] opcode, [5:3] X, [2:0] Y.
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub.
- Opcode 001 consumes the following RAM word as the immediate. All other opcodes are a single word.

RAM:
- 2^AW x 9, one write port and one read port, read latency 1 cycle.
- Contents are not cleared by `Reset`.

States:
- IDLE: outputs quiescent.
  - `Start`: PC←0, InstrCount←0, latch ProgLen.
  - If ProgLen==0 → HALT, else → FETCH_I.
- FETCH_I: read address = PC → LATCH_I.
- LATCH_I: IR←rdata.
  - If IR[8:6]==001 and PC+1 ≥ ProgLen: ErrCode←10 → ERROR.
  - Else if IR[8:6]==001: read address = PC+1 → LATCH_D.
  - Else → ISSUE.
- LATCH_D: IMM←rdata → ISSUE.
- ISSUE: `DIN`=IR, `Run`=1 for exactly one cycle; timeout counter←0 → WAIT.
- WAIT:
  - `DIN`=IMM for mvi, IR otherwise; `Run`=0.
  - On `Done`: PC←PC+2 for mvi, else PC+1; InstrCount +1.
  - After `Done`: if new PC ≥ ProgLen → HALT, else → FETCH_I.
  - Without `Done`: counter +1. If counter reaches TIMEOUT with no `Done`: ErrCode←01 → ERROR.
- HALT: `Halted`=1. `Start` restarts exactly as from IDLE.
- ERROR: `Error`=1; PC frozen at the offending instruction. Only `Reset` exits.

Output rules:
- Outside ISSUE and WAIT, `DIN` is 0.
- PC arithmetic is AW+1 bits wide, so ProgLen = 2^AW runs the full RAM without wrap.

## Timing
- Reset values: state IDLE, `DIN`=0, `Run`=0, `PC`=0, `InstrCount`=0, `Busy`=0, `Halted`=0, `Error`=0, `ErrCode`=00.
- Start-to-Run latency, counting the `Start`-sampling edge as edge 0:
  - Non-mvi: `Run` is high in cycle 3.
  - mvi: `Run` is high in cycle 4.
- Done-to-next-Run: 3 cycles (4 if the next instruction is mvi).
- `Done` may arrive in the first WAIT cycle (the cycle after `Run`). `Done` on the TIMEOUT-th WAIT cycle is accepted; later is timeout.
- `Done` asserted outside WAIT (including during ISSUE) is ignored.
- `Start` while Busy and `WrEn` while Busy are ignored; RAM is unchanged.
- `WrEn` in HALT with simultaneous `Start`: the write completes, then the run starts. The fetch at address 0 sees the new data if WrAddr==0.
- `Reset` mid-operation: next cycle all outputs take reset values; no further `Run`; RAM retained.

## Test plan
- Load [0]=9'o100, [1]=5, [2]=9'o010, [3]=9'o201, ProgLen=4; stub processor asserts `Done` 2 cycles after `Run`.
  - Expected: three `Run` pulses with `DIN` 9'o100, 9'o010, 9'o201.
  - Expected: `DIN`=5 during the mvi WAIT.
  - Expected: final `PC`=4, `InstrCount`=3, `Halted`=1.
- ProgLen=0, `Start` → `Halted`=1 the cycle after; no `Run`.
- ProgLen=1, [0]=9'o100 → `Error`=1, `ErrCode`=10, `PC`=0; no `Run`.
- TIMEOUT=16, stub never asserts `Done` → `Error`=1 with `ErrCode`=01 exactly 17 cycles after `Run`. Repeat with `Done` on WAIT cycle 16 → accepted, no error.
- Assert `Reset` during WAIT of instruction 2 → next cycle all outputs 0. A subsequent `Start` replays the program from address 0 with identical output.
- `WrEn` to [2] while Busy → RAM unchanged; the second run still issues the original word.

Source files
------------

// File: rtl/proc_instr_feeder_if.sv
// Bus between the instruction feeder (master) and its host/processor side (slave).
// Carries program load, run control, the processor handshake and status.
interface proc_instr_feeder_if #(
    parameter int AW = 8
);
    logic          Start;
    logic [AW:0]   ProgLen;
    logic          WrEn;
    logic [AW-1:0] WrAddr;
    logic [8:0]    WrData;
    logic          Done;
    logic [8:0]    DIN;
    logic          Run;
    logic [AW:0]   PC;
    logic [15:0]   InstrCount;
    logic          Busy;
    logic          Halted;
    logic          Error;
    logic [1:0]    ErrCode;

    modport master (
        input  Start, ProgLen, WrEn, WrAddr, WrData, Done,
        output DIN, Run, PC, InstrCount, Busy, Halted, Error, ErrCode
    );

    modport slave (
        output Start, ProgLen, WrEn, WrAddr, WrData, Done,
        input  DIN, Run, PC, InstrCount, Busy, Halted, Error, ErrCode
    );
endinterface

// File: rtl/proc_instr_feeder.sv
// Instruction sequencer: steps a program held in local RAM, issuing each word with a
// one-cycle Run pulse (plus the immediate for mvi) and waiting for the processor's Done.
module proc_instr_feeder #(
    parameter int AW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic Clock,
    input  logic Reset,
    proc_instr_feeder_if.master bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH_I = 3'd1;
    localparam logic [2:0] S_LATCH_I = 3'd2;
    localparam logic [2:0] S_LATCH_D = 3'd3;
    localparam logic [2:0] S_ISSUE   = 3'd4;
    localparam logic [2:0] S_WAIT    = 3'd5;
    localparam logic [2:0] S_HALT    = 3'd6;
    localparam logic [2:0] S_ERROR   = 3'd7;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [8:0]    r_mem [0:(2**AW)-1];
    logic [8:0]    r_rdata;
    logic [8:0]    r_ir;
    logic [8:0]    r_imm;
    logic [2:0]    r_state;
    logic [AW:0]   r_pc;
    logic [AW:0]   r_len;
    logic [15:0]   r_icount;
    logic [7:0]    r_tcnt;
    logic [1:0]    r_err;

    logic          w_idle_like;
    logic          w_is_mvi;
    logic          w_rd_mvi;
    logic [AW:0]   w_pc_inc;
    logic [AW:0]   w_pc_next;
    logic [AW-1:0] w_raddr;

    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_HALT);
    assign w_is_mvi    = (r_ir[8:6] == 3'b001);
    assign w_rd_mvi    = (r_rdata[8:6] == 3'b001);
    assign w_pc_inc    = r_pc + (AW+1)'(1);
    assign w_pc_next   = w_is_mvi ? (r_pc + (AW+1)'(2)) : w_pc_inc;
    // The immediate read is launched from LATCH_I so it lands in LATCH_D.
    assign w_raddr     = (r_state == S_LATCH_I) ? w_pc_inc[AW-1:0] : r_pc[AW-1:0];

    // Program RAM survives Reset; writes only while not executing.
    always_ff @(posedge Clock) begin
        if (bus.WrEn && w_idle_like)
            r_mem[bus.WrAddr] <= bus.WrData;
        r_rdata <= r_mem[w_raddr];
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_len    <= '0;
            r_icount <= '0;
            r_tcnt   <= '0;
            r_err    <= 2'b00;
            r_ir     <= '0;
            r_imm    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (bus.Start) begin
                        r_pc     <= '0;
                        r_icount <= '0;
                        r_len    <= bus.ProgLen;
                        r_state  <= (bus.ProgLen == '0) ? S_HALT : S_FETCH_I;
                    end
                end
                S_FETCH_I: r_state <= S_LATCH_I;
                S_LATCH_I: begin
                    r_ir <= r_rdata;
                    if (w_rd_mvi && (w_pc_inc >= r_len)) begin
                        r_err   <= 2'b10;
                        r_state <= S_ERROR;
                    end else if (w_rd_mvi) begin
                        r_state <= S_LATCH_D;
                    end else begin
                        r_state <= S_ISSUE;
                    end
                end
                S_LATCH_D: begin
                    r_imm   <= r_rdata;
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_tcnt  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Done on the last allowed WAIT cycle still wins over the timeout.
                    if (bus.Done) begin
                        r_pc <= w_pc_next;
                        if (r_icount != 16'hFFFF)
                            r_icount <= r_icount + 16'd1;
                        r_state <= (w_pc_next >= r_len) ? S_HALT : S_FETCH_I;
                    end else if (r_tcnt == TO_LAST) begin
                        r_err   <= 2'b01;
                        r_state <= S_ERROR;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                S_ERROR: r_state <= S_ERROR;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.Run        = (r_state == S_ISSUE);
    assign bus.DIN        = (r_state == S_ISSUE) ? r_ir :
                            (r_state == S_WAIT)  ? (w_is_mvi ? r_imm : r_ir) : 9'd0;
    assign bus.PC         = r_pc;
    assign bus.InstrCount = r_icount;
    assign bus.Busy       = !(w_idle_like || (r_state == S_ERROR));
    assign bus.Halted     = (r_state == S_HALT);
    assign bus.Error      = (r_state == S_ERROR);
    assign bus.ErrCode    = r_err;
endmodule

// File: tb/tb_proc_instr_feeder.sv
// Scoreboard bench: expected Run words, WAIT words and Done delays are queued per
// instruction; a monitor and a stub processor pop and compare as the DUT presents them.
module tb_proc_instr_feeder;
    logic Clock;
    logic Reset;
    int   cyc;
    int   n_cmp;
    int   n_err;
    int   n_run;
    int   run_target;
    int   st_cyc;
    int   nr;

    logic [8:0] exp_run  [$];
    logic [8:0] exp_wait [$];
    int         dly_q    [$];
    int         run_cycles [$];

    proc_instr_feeder_if #(.AW(8)) bus();

    proc_instr_feeder #(.AW(8), .TIMEOUT(16)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every Run pulse must match the next queued instruction word.
    always @(negedge Clock) begin
        if (bus.Run === 1'b1) begin
            n_run++;
            run_cycles.push_back(cyc);
            if (exp_run.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL run_unexpected: got DIN %0h with no expected issue", bus.DIN);
            end else begin
                chk("run_din", 32'(bus.DIN), 32'(exp_run.pop_front()));
            end
        end
    end

    // Stub processor: Done on WAIT cycle d (d=0 means never), checking DIN at that point.
    initial begin
        bus.Done = 1'b0;
        forever begin
            @(negedge Clock);
            if (bus.Run === 1'b1) begin
                int d;
                d = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
                if (d > 0) begin
                    repeat (d) @(negedge Clock);
                    if (exp_wait.size() != 0)
                        chk("wait_din", 32'(bus.DIN), 32'(exp_wait.pop_front()));
                    bus.Done = 1'b1;
                    @(negedge Clock);
                    bus.Done = 1'b0;
                end
            end
        end
    end

    task automatic wait_until(input int sel, input string nm);
        int lim;
        bit hit;
        lim = 300;
        hit = 1'b0;
        while (!hit && lim > 0) begin
            @(negedge Clock); #1;
            case (sel)
                0:       hit = bus.Halted;
                1:       hit = bus.Error;
                default: hit = (n_run >= run_target);
            endcase
            lim--;
        end
        if (!hit) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: timed out waiting", nm);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [8:0] d);
        @(negedge Clock);
        bus.WrEn = 1'b1; bus.WrAddr = a; bus.WrData = d;
        @(negedge Clock);
        bus.WrEn = 1'b0;
    endtask

    task automatic start(input logic [8:0] len);
        @(negedge Clock);
        bus.Start = 1'b1; bus.ProgLen = len; st_cyc = cyc;
        @(negedge Clock);
        bus.Start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic push_prog();
        exp_run.push_back(9'o100); exp_wait.push_back(9'd5);   dly_q.push_back(2);
        exp_run.push_back(9'o010); exp_wait.push_back(9'o010); dly_q.push_back(2);
        exp_run.push_back(9'o201); exp_wait.push_back(9'o201); dly_q.push_back(2);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_a"}, 32'({bus.DIN, bus.Run, bus.PC}), 32'd0);
        chk({nm, "_b"}, 32'({bus.InstrCount, bus.Busy, bus.Halted, bus.Error, bus.ErrCode}), 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_run = 0; run_target = 0;
        Reset = 1'b1;
        bus.Start = 1'b0; bus.ProgLen = '0;
        bus.WrEn = 1'b0; bus.WrAddr = '0; bus.WrData = '0;
        repeat (3) @(negedge Clock);
        chk_zero("reset");
        Reset = 1'b0;

        // Main program: mvi 5, mv, add.
        wr(8'd0, 9'o100); wr(8'd1, 9'd5); wr(8'd2, 9'o010); wr(8'd3, 9'o201);
        push_prog();
        start(9'd4);
        wait_until(0, "halt_main");
        chk("lat_mvi", 32'(run_cycles[0] - st_cyc), 32'd4);
        chk("done_to_run", 32'(run_cycles[1] - run_cycles[0]), 32'd5);
        chk("main_pc", 32'(bus.PC), 32'd4);
        chk("main_cnt", 32'(bus.InstrCount), 32'd3);
        chk("main_stat", 32'({bus.Busy, bus.Halted, bus.Error}), 32'b010);

        // Write to [2] while busy must be dropped; this run fetches [2] after the write.
        push_prog();
        run_target = n_run + 1;
        start(9'd4);
        wait_until(2, "run_busy");
        chk("busy_during_run", 32'(bus.Busy), 32'd1);
        wr(8'd2, 9'o777);
        wait_until(0, "halt_busywr");
        chk("busywr_cnt", 32'(bus.InstrCount), 32'd3);

        // Reset in WAIT of the second instruction, then replay from address 0.
        exp_run.push_back(9'o100); exp_wait.push_back(9'd5); dly_q.push_back(2);
        exp_run.push_back(9'o010); dly_q.push_back(0);
        run_target = n_run + 2;
        start(9'd4);
        wait_until(2, "run_second");
        @(negedge Clock); #1;
        Reset = 1'b1;
        @(negedge Clock); #1;
        chk_zero("mid_reset");
        Reset = 1'b0;
        chk("mid_reset_q", 32'(exp_run.size() + exp_wait.size() + dly_q.size()), 32'd0);
        push_prog();
        start(9'd4);
        wait_until(0, "halt_replay");
        chk("replay_pc", 32'(bus.PC), 32'd4);
        chk("replay_cnt", 32'(bus.InstrCount), 32'd3);

        // Empty program halts on the next cycle with no issue.
        do_reset();
        nr = n_run;
        start(9'd0);
        #1;
        chk("len0_halted", 32'({bus.Halted, bus.Busy}), 32'b10);
        chk("len0_norun", 32'(n_run), 32'(nr));

        // Truncated mvi at the last word.
        do_reset();
        wr(8'd0, 9'o100);
        nr = n_run;
        start(9'd1);
        wait_until(1, "err_trunc");
        chk("trunc_code", 32'(bus.ErrCode), 32'd2);
        chk("trunc_pc", 32'(bus.PC), 32'd0);
        chk("trunc_norun", 32'(n_run), 32'(nr));

        // Done never arrives: error exactly 17 cycles after Run.
        do_reset();
        wr(8'd0, 9'o201);
        exp_run.push_back(9'o201); dly_q.push_back(0);
        start(9'd1);
        wait_until(1, "err_timeout");
        chk("lat_plain", 32'(run_cycles[$] - st_cyc), 32'd3);
        chk("timeout_cyc", 32'(cyc - run_cycles[$]), 32'd17);
        chk("timeout_code", 32'(bus.ErrCode), 32'd1);
        chk("timeout_pc", 32'(bus.PC), 32'd0);

        // Done on WAIT cycle 16 is still accepted.
        do_reset();
        exp_run.push_back(9'o201); exp_wait.push_back(9'o201); dly_q.push_back(16);
        start(9'd1);
        wait_until(0, "halt_late_done");
        chk("late_done_err", 32'({bus.Error, bus.ErrCode}), 32'd0);
        chk("late_done_cnt", 32'(bus.InstrCount), 32'd1);

        // Write in HALT together with Start: the fetch at 0 sees the new word.
        exp_run.push_back(9'o010); exp_wait.push_back(9'o010); dly_q.push_back(2);
        @(negedge Clock);
        bus.WrEn = 1'b1; bus.WrAddr = 8'd0; bus.WrData = 9'o010;
        bus.Start = 1'b1; bus.ProgLen = 9'd1;
        @(negedge Clock);
        bus.WrEn = 1'b0; bus.Start = 1'b0;
        wait_until(0, "halt_wrstart");
        chk("wrstart_pc", 32'(bus.PC), 32'd1);

        repeat (3) @(negedge Clock);
        chk("queues_drained", 32'(exp_run.size() + exp_wait.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
